// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one variable-latency memory port between IFU and LSU.
// LSU has priority, a streak limit keeps IFU from starving, and a watchdog aborts hung transactions.
module mem_arbiter #(
  parameter int MAX_LS_STREAK = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_ack,
  output logic [63:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_ack,
  output logic [63:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  localparam int SW = ($clog2(MAX_LS_STREAK + 1) < 3) ? 3 : $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);
  localparam logic [15:0]   WD_LIMIT   = 16'(TIMEOUT);

  // state   | meaning
  // IDLE    | no transaction, arbitrate each cycle
  // GNT_IF  | IFU transaction in flight
  // GNT_LS  | LSU transaction in flight
  // RECOVER | one-cycle settle after completion or abort
  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_LS, RECOVER} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic [15:0]   wdog;
  logic          in_if, in_ls, wd_expired;

  assign in_if      = (state == GNT_IF) && !rst;
  assign in_ls      = (state == GNT_LS) && !rst;
  // A real ack in the timeout cycle wins over the abort.
  assign wd_expired = (wdog == WD_LIMIT) && !mem_ack;

  assign if_ack   = in_if && (mem_ack || wd_expired);
  assign if_err   = in_if && wd_expired;
  assign if_rdata = (in_if && mem_ack) ? mem_rdata : '0;
  assign ls_ack   = in_ls && (mem_ack || wd_expired);
  assign ls_err   = in_ls && wd_expired;
  assign ls_rdata = (in_ls && mem_ack) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      streak    <= '0;
      wdog      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Saturated streak only yields to IFU when IFU is actually waiting.
          if (ls_req && (streak < STREAK_MAX || !if_req)) begin
            state     <= GNT_LS;
            mem_req   <= 1'b1;
            mem_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            mem_wmask <= ls_wmask;
            wdog      <= '0;
            if (if_req)
              streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
            else
              streak <= '0;
          end else if (if_req) begin
            state     <= GNT_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wmask <= 8'hFF;
            wdog      <= '0;
            streak    <= '0;
          end
        end
        GNT_IF, GNT_LS: begin
          if (mem_ack || wdog == WD_LIMIT) begin
            mem_req <= 1'b0;
            state   <= RECOVER;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch/store, streak order, timeouts, reset abort, stray acks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ack;
  logic [63:0] if_rdata;
  logic        if_err;
  logic        ls_req;
  logic        ls_we;
  logic [63:0] ls_addr;
  logic [63:0] ls_wdata;
  logic [7:0]  ls_wmask;
  logic        ls_ack;
  logic [63:0] ls_rdata;
  logic        ls_err;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.MAX_LS_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_mem_req(input string tag);
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) step();
    chk(tag, 64'(mem_req), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "bench did not finish");
  end

  logic [63:0] exp_order [6];

  initial begin
    exp_order = '{64'h2000, 64'h2000, 64'h2000, 64'h2000, 64'h1000, 64'h2000};
    rst = 1'b1; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0;
    ls_wdata = 0; ls_wmask = 0; mem_ack = 0; mem_rdata = 0;
    step(); step();
    mem_ack = 1'b1;
    #1;
    chk("rst_if_ack", 64'(if_ack), 0);
    chk("rst_ls_ack", 64'(ls_ack), 0);
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_mem_wmask", 64'(mem_wmask), 0);
    mem_ack = 1'b0;
    step();
    rst = 1'b0;

    // Single fetch: mem_ack one cycle after mem_req rises -> if_ack at N+2.
    if_req = 1'b1; if_addr = 64'h8000_0000;
    step();
    chk("fetch_mem_req", 64'(mem_req), 1);
    chk("fetch_mem_addr", mem_addr, 64'h8000_0000);
    chk("fetch_mem_we", 64'(mem_we), 0);
    chk("fetch_mem_wmask", 64'(mem_wmask), 64'hFF);
    chk("fetch_no_early_ack", 64'(if_ack), 0);
    step();
    mem_ack = 1'b1; mem_rdata = 64'h0010_0073;
    #1;
    chk("fetch_if_ack", 64'(if_ack), 1);
    chk("fetch_if_rdata", if_rdata, 64'h0010_0073);
    chk("fetch_if_err", 64'(if_err), 0);
    chk("fetch_ls_ack", 64'(ls_ack), 0);
    chk("fetch_ls_rdata", ls_rdata, 0);
    step();
    if_req = 1'b0;
    #1;
    chk("recover_mem_req", 64'(mem_req), 0);
    chk("stray_recover_if_ack", 64'(if_ack), 0);
    chk("stray_recover_ls_ack", 64'(ls_ack), 0);
    step();
    #1;
    chk("stray_idle_if_ack", 64'(if_ack), 0);
    chk("stray_idle_ls_ack", 64'(ls_ack), 0);
    step();
    mem_ack = 1'b0;
    #1;
    chk("stray_no_grant", 64'(mem_req), 0);

    // Single store; payload changes after grant must not leak through.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_1000; ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
    step();
    ls_wdata = 64'h1111_2222; ls_addr = 64'h0;
    #1;
    chk("store_mem_req", 64'(mem_req), 1);
    chk("store_mem_we", 64'(mem_we), 1);
    chk("store_mem_addr", mem_addr, 64'h8000_1000);
    chk("store_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
    chk("store_mem_wmask", 64'(mem_wmask), 64'h0F);
    mem_ack = 1'b1; mem_rdata = 64'h0;
    #1;
    chk("store_ls_ack", 64'(ls_ack), 1);
    chk("store_ls_err", 64'(ls_err), 0);
    chk("store_if_ack", 64'(if_ack), 0);
    step();
    mem_ack = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    step(); step();

    // Streak limiter: LS x4, IF, LS with both requests held.
    if_req = 1'b1; ls_req = 1'b1; if_addr = 64'h1000; ls_addr = 64'h2000;
    for (int g = 0; g < 6; g++) begin
      wait_mem_req($sformatf("streak_wait_%0d", g));
      chk($sformatf("streak_grant_%0d", g), mem_addr, exp_order[g]);
      mem_ack = 1'b1; mem_rdata = 64'(g + 100);
      #1;
      if (exp_order[g] == 64'h2000) begin
        chk($sformatf("streak_ls_ack_%0d", g), 64'(ls_ack), 1);
        chk($sformatf("streak_ls_rdata_%0d", g), ls_rdata, 64'(g + 100));
        chk($sformatf("streak_if_idle_%0d", g), 64'(if_ack), 0);
      end else begin
        chk($sformatf("streak_if_ack_%0d", g), 64'(if_ack), 1);
        chk($sformatf("streak_ls_idle_%0d", g), 64'(ls_ack), 0);
      end
      step();
      mem_ack = 1'b0;
    end
    if_req = 1'b0; ls_req = 1'b0;
    step(); step();

    // LSU timeout: abort exactly 8 cycles after mem_req rises.
    ls_req = 1'b1; ls_addr = 64'h3000; mem_rdata = 64'hBAD0_BAD0;
    wait_mem_req("to_wait");
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k < 8) chk($sformatf("to_early_%0d", k), 64'(ls_ack), 0);
    end
    chk("to_ls_ack", 64'(ls_ack), 1);
    chk("to_ls_err", 64'(ls_err), 1);
    chk("to_ls_rdata", ls_rdata, 0);
    step();
    ls_req = 1'b0;
    chk("to_mem_req_drop", 64'(mem_req), 0);
    if_req = 1'b1; if_addr = 64'h8000_0004;
    wait_mem_req("to_fetch_wait");
    chk("to_fetch_addr", mem_addr, 64'h8000_0004);
    mem_ack = 1'b1; mem_rdata = 64'h13;
    #1;
    chk("to_fetch_ack", 64'(if_ack), 1);
    chk("to_fetch_rdata", if_rdata, 64'h13);
    chk("to_fetch_err", 64'(if_err), 0);
    step();
    mem_ack = 1'b0; if_req = 1'b0;
    step(); step();

    // Ack in the timeout cycle wins.
    if_req = 1'b1; if_addr = 64'h8000_0010;
    wait_mem_req("race_wait");
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k < 8) chk($sformatf("race_early_%0d", k), 64'(if_ack), 0);
    end
    mem_ack = 1'b1; mem_rdata = 64'h55AA_55AA;
    #1;
    chk("race_if_ack", 64'(if_ack), 1);
    chk("race_if_err", 64'(if_err), 0);
    chk("race_if_rdata", if_rdata, 64'h55AA_55AA);
    step();
    mem_ack = 1'b0; if_req = 1'b0;
    step(); step();

    // Reset while in GNT_IF: no ack, mem_req drops, fresh request regranted.
    if_req = 1'b1; if_addr = 64'h8000_0008;
    wait_mem_req("rstmid_wait");
    step();
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 64'h77;
    #1;
    chk("rstmid_if_ack", 64'(if_ack), 0);
    chk("rstmid_if_err", 64'(if_err), 0);
    step();
    rst = 1'b0; mem_ack = 1'b0;
    #1;
    chk("rstmid_mem_req", 64'(mem_req), 0);
    chk("rstmid_mem_addr", mem_addr, 0);
    chk("rstmid_if_ack_after", 64'(if_ack), 0);
    step();
    chk("rstmid_regrant", 64'(mem_req), 1);
    chk("rstmid_regrant_addr", mem_addr, 64'h8000_0008);
    mem_ack = 1'b1; mem_rdata = 64'h99;
    #1;
    chk("rstmid_final_ack", 64'(if_ack), 1);
    step();
    mem_ack = 1'b0; if_req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
